riscv_iter_alu: RTL and testbench
=================================

// Module: riscv_iter_alu
// PURPOSE
// - Parametrised successor to the single-cycle RISC-V ALU: same 4-bit ALUSel op space.
// - Adds real arithmetic shift-right, signed SLT, and iterative MUL/MULHU/DIVU/REMU
//   via a shift-add / restoring-divide datapath.
// - Adds a start/busy/done handshake.
// - Sits in the execute stage. The pipeline stalls on busy; result writeback happens on done.
// PARAMETERS
// - XLEN     32  operand/result width, any value >= 8
// - SHAMT_W  $clog2(XLEN)  shift-amount width; derived localparam, not overridable
// - HAS_MDIV 1   0: ops 1001/1010/1011/1101 complete single-cycle returning b (no iterative datapath)
// PORTS
// - clk     in   1        rising-edge clock
// - rst     in   1        synchronous, active-high reset
// - start   in   1        request; operands and op sampled when accepted
// - ALUSel  in   4        operation select
// - a       in   XLEN     operand A (rs1)
// - b       in   XLEN     operand B (rs2/imm)
// - busy    out  1        high while iterative op in progress
// - done    out  1        one-cycle pulse; result valid from this cycle
// - result  out  XLEN     registered; held until next accepted start
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, done=0, result=0. Mid-operation reset aborts; partial result discarded.
// - Op map (a, b unsigned unless noted):
//   - 0000 a+b; 0001 a&b; 0010 a|b; 0011 a^b
//   - 0100 a>>b[SHAMT_W-1:0]; 0101 $signed(a)>>>b[SHAMT_W-1:0]; 0110 a<<b[SHAMT_W-1:0]
//   - 0111 sltu {0,a<b}; 1000 b (lui); 1100 a-b; 1110 slt signed; 1111 b
//   - 1001 remu; 1010 mulhu (upper XLEN of 2*XLEN product); 1011 mul (lower XLEN); 1101 divu
// - Arithmetic wraps modulo 2^XLEN; no flags.
// - FSM states IDLE, CALC, DONE:
//   - Accept: start=1 while state!=CALC.
//     - Single-cycle op: result registered, next state DONE.
//     - Iterative op: operands latched, counter=XLEN-1, next state CALC.
//   - CALC: one iteration per cycle. Counter==0 -> write result, go to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is accepted (back-to-back, no bubble).
//   - start while busy=1 is ignored; no queuing, operand changes are don't-care.
// - Latency (start cycle = 0): single-cycle done at cycle 1; iterative done at cycle XLEN+1.
//   busy=1 exactly cycles 1..XLEN.
// - Divide by zero: no iteration. divu -> all-ones, remu -> a. done at cycle 1, busy never asserted.
// - Multiply: 2*XLEN accumulator. Divide: restoring, XLEN+1-bit partial remainder.
// - The datapath must not depend on a combinational '*' or '%'.
// - result changes only on the cycle done rises (or reset); stable otherwise.
// STRUCTURE
// - Shared package riscv_alu_pkg:
//   - ALUSel localparams (ALU_ADD..ALU_PASSB2)
//   - FSM state typedef/encoding
//   - is_iterative(op) function, shared with the decoder's stall logic
// - One sub-module riscv_iter_muldiv (XLEN): start/op/a/b in, iterates, emits res + last.
//   - Top holds the FSM, single-cycle ops and the result register.
// TESTING
// - add 0x7FFFFFFF+1 -> done cycle 1, result 0x80000000, busy never high.
// - sra a=0x80000000,b=4 -> 0xF8000000; srl same -> 0x08000000; slt 0xFFFFFFFF<1 -> 1; sltu -> 0.
// - mul 0xFFFFFFFF*2 -> 0xFFFFFFFE, mulhu -> 0x00000001.
//   Both: done at cycle 33, busy cycles 1..32.
// - divu 100/7 -> 14, remu -> 2.
//   divu 5/0 -> 0xFFFFFFFF, remu 5/0 -> 5, both at cycle 1.
//   A second start during busy is ignored; result unchanged.
// - Back-to-back: new start in the done cycle accepted; next done 1 (or 33) cycles later.
// - rst at cycle 10 of a mul -> cycle 11 busy=0, done=0, result=0; a following add completes normally.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the iterative RISC-V ALU: op encodings, FSM states and
// the iterative-op classifier also used by the decoder's stall logic.
package riscv_alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_AND    = 4'b0001;
  localparam logic [3:0] ALU_OR     = 4'b0010;
  localparam logic [3:0] ALU_XOR    = 4'b0011;
  localparam logic [3:0] ALU_SRL    = 4'b0100;
  localparam logic [3:0] ALU_SRA    = 4'b0101;
  localparam logic [3:0] ALU_SLL    = 4'b0110;
  localparam logic [3:0] ALU_SLTU   = 4'b0111;
  localparam logic [3:0] ALU_LUI    = 4'b1000;
  localparam logic [3:0] ALU_REMU   = 4'b1001;
  localparam logic [3:0] ALU_MULHU  = 4'b1010;
  localparam logic [3:0] ALU_MUL    = 4'b1011;
  localparam logic [3:0] ALU_SUB    = 4'b1100;
  localparam logic [3:0] ALU_DIVU   = 4'b1101;
  localparam logic [3:0] ALU_SLT    = 4'b1110;
  localparam logic [3:0] ALU_PASSB2 = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // True for ops that need the multi-cycle multiply/divide datapath.
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == ALU_REMU) || (op == ALU_MULHU) ||
           (op == ALU_MUL)  || (op == ALU_DIVU);
  endfunction

  function automatic logic is_divide(input logic [3:0] op);
    return (op == ALU_REMU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/riscv_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Loads on start, raises last in the cycle whose iteration produces the final res.
module riscv_iter_muldiv
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            last
);

  localparam int CNT_W = $clog2(XLEN);

  logic [3:0]        op_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              run_reg;

  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_mul_next;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic [XLEN:0]     div_rem_full;
  logic [XLEN-1:0]   div_q_next;
  logic [2*XLEN-1:0] acc_div_next;
  logic [2*XLEN-1:0] acc_next;
  logic              is_mul;
  logic              div_rem_unused;

  assign acc_hi = acc_reg[2*XLEN-1:XLEN];
  assign acc_lo = acc_reg[XLEN-1:0];

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
  assign acc_mul_next = {mul_sum, acc_lo[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
  // The remainder stays below the divisor, so its top trial bit is always zero after restore.
  assign div_trial      = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff       = div_trial - {1'b0, opnd_reg};
  assign div_rem_full   = div_diff[XLEN] ? div_trial : div_diff;
  assign div_q_next     = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
  assign acc_div_next   = {div_rem_full[XLEN-1:0], div_q_next};
  assign div_rem_unused = div_rem_full[XLEN];

  assign is_mul   = (op_reg == ALU_MUL) || (op_reg == ALU_MULHU);
  assign acc_next = is_mul ? acc_mul_next : acc_div_next;

  assign res  = ((op_reg == ALU_MUL) || (op_reg == ALU_DIVU)) ?
                acc_next[XLEN-1:0] : acc_next[2*XLEN-1:XLEN];
  assign last = run_reg && (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= ALU_ADD;
      opnd_reg <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
    end else if (start) begin
      op_reg   <= op;
      opnd_reg <= b;
      acc_reg  <= {{XLEN{1'b0}}, a};
      cnt_reg  <= CNT_W'(XLEN - 1);
      run_reg  <= 1'b1;
    end else if (run_reg) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg - 1'b1;
      if (cnt_reg == '0) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/riscv_iter_alu.sv
// Execute-stage RISC-V ALU with start/busy/done handshake; single-cycle ops finish
// in one cycle, multiply/divide iterate one bit per cycle in riscv_iter_muldiv.
module riscv_iter_alu
  import riscv_alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int HAS_MDIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      ALUSel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_t        state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [XLEN-1:0]   result_reg;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               div_zero;
  logic               go_iter;
  logic               accept;
  logic               mdiv_start;
  logic [XLEN-1:0]    mdiv_res;
  logic               mdiv_last;

  assign shamt    = b[SHAMT_W-1:0];
  assign div_zero = is_divide(ALUSel) && (b == '0);
  assign go_iter  = (HAS_MDIV != 0) && is_iterative(ALUSel) && !div_zero;
  assign accept   = start && (state_reg != CALC);
  assign mdiv_start = accept && go_iter;

  // Iterative ops only land here when they finish in one cycle (divide by zero, or no datapath).
  always_comb begin
    alu_res = '0;
    case (ALUSel)
      ALU_ADD:    alu_res = a + b;
      ALU_AND:    alu_res = a & b;
      ALU_OR:     alu_res = a | b;
      ALU_XOR:    alu_res = a ^ b;
      ALU_SRL:    alu_res = a >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(a) >>> shamt);
      ALU_SLL:    alu_res = a << shamt;
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_LUI:    alu_res = b;
      ALU_SUB:    alu_res = a - b;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_PASSB2: alu_res = b;
      ALU_REMU:   alu_res = (HAS_MDIV != 0) ? a : b;
      ALU_DIVU:   alu_res = (HAS_MDIV != 0) ? {XLEN{1'b1}} : b;
      default:    alu_res = b;
    endcase
  end

  generate
    if (HAS_MDIV != 0) begin : g_mdiv
      riscv_iter_muldiv #(
        .XLEN (XLEN)
      ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (mdiv_start),
        .op    (ALUSel),
        .a     (a),
        .b     (b),
        .res   (mdiv_res),
        .last  (mdiv_last)
      );
    end else begin : g_no_mdiv
      assign mdiv_res  = '0;
      assign mdiv_last = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        CALC: begin
          if (mdiv_last) begin
            result_reg <= mdiv_res;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE when nothing arrives.
          if (accept && go_iter) begin
            busy_reg  <= 1'b1;
            state_reg <= CALC;
          end else if (accept) begin
            result_reg <= alu_res;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_riscv_iter_alu.sv
// Self-checking bench for riscv_iter_alu: directed corner cases plus random ops
// against a plain-arithmetic reference model (result, latency, busy duration).
module tb_riscv_iter_alu;
  import riscv_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_iter_alu #(
    .XLEN     (32),
    .HAS_MDIV (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ALUSel (alu_sel),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] prod;
    int          sh;
    prod = {32'd0, x} * {32'd0, y};
    sh   = int'(y % 32);
    case (op)
      4'd0:  return x + y;
      4'd1:  return x & y;
      4'd2:  return x | y;
      4'd3:  return x ^ y;
      4'd4:  return x >> sh;
      4'd5:  return $unsigned($signed(x) >>> sh);
      4'd6:  return x << sh;
      4'd7:  return (x < y) ? 32'd1 : 32'd0;
      4'd8:  return y;
      4'd9:  return (y == 0) ? x : (x % y);
      4'd10: return prod[63:32];
      4'd11: return prod[31:0];
      4'd12: return x - y;
      4'd13: return (y == 0) ? 32'hFFFF_FFFF : (x / y);
      4'd14: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return y;
    endcase
  endfunction

  // Cycles from start to done: mul/div family takes XLEN+1 unless dividing by zero.
  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
    if (op == 4'd10 || op == 4'd11) return 33;
    if ((op == 4'd9 || op == 4'd13) && y != 0) return 33;
    return 1;
  endfunction

  // Called #1 after a rising edge; that cycle is cycle 0. Returns in the done cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] oa,
                        input logic [31:0] ob, input int intrude);
    logic [31:0] exp;
    int lat, cyc, bc;
    bit got;
    exp = ref_alu(op, oa, ob);
    lat = ref_lat(op, ob);
    start = 1'b1; alu_sel = op; a = oa; b = ob;
    cyc = 0; bc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == intrude) begin
        start = 1'b1; alu_sel = ALU_ADD; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) got = 1'b1;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_busycycles"}, 32'(bc), 32'(lat - 1));
    check({tag, "_result"}, result, exp);
    $display("%s: op=%h a=%08h b=%08h result=%08h expected=%08h done_cycle=%0d",
             tag, op, oa, ob, result, exp, cyc);
  endtask

  task automatic idle_check(input string tag, input logic [31:0] held);
    @(posedge clk); #1;
    check({tag, "_donepulse"}, 32'(done), 32'd0);
    check({tag, "_idlebusy"}, 32'(busy), 32'd0);
    check({tag, "_held"}, result, held);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; alu_sel = 4'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 0);
    idle_check("add_ovf", 32'h8000_0000);

    // Back-to-back single-cycle ops issued in each done cycle.
    run_op("sra", ALU_SRA, 32'h8000_0000, 32'd4, 0);
    run_op("srl", ALU_SRL, 32'h8000_0000, 32'd4, 0);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
    idle_check("sltu", 32'd0);

    run_op("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("divu", ALU_DIVU, 32'd100, 32'd7, 0);
    run_op("remu", ALU_REMU, 32'd100, 32'd7, 0);
    run_op("divu_z", ALU_DIVU, 32'd5, 32'd0, 0);
    run_op("remu_z", ALU_REMU, 32'd5, 32'd0, 0);
    idle_check("remu_z", 32'd5);

    run_op("divu_intr", ALU_DIVU, 32'd100, 32'd7, 5);
    idle_check("divu_intr", 32'd14);

    // Reset in the middle of a multiply aborts it.
    start = 1'b1; alu_sel = ALU_MUL; a = 32'hFFFF_FFFF; b = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    rst = 1'b0;
    run_op("add_after_rst", ALU_ADD, 32'd3, 32'd4, 0);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(15));
      ra  = $urandom;
      case ($urandom_range(3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(40));
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, 0);
      if ($urandom_range(1) == 1) idle_check("rand", ref_alu(rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
